imgproc_frame_ctrl: RTL
=======================

# imgproc_frame_ctrl

Frame sequencer and configuration controller for the camera image-processing path (line buffer → greyscale → convolution). It tracks frame and pixel position from the sensor's frame/data valid strobes and produces registered X/Y coordinates for the datapath. It latches filter-mode change requests and applies them only at frame boundaries, driving the convolution direction and bypass controls. It also generates the border-masked, latency-aligned output valid and signals frame completion.

## Interface
Parameters:
- IMG_W, 640: active pixels per line.
- IMG_H, 480: active lines per frame.
- PIPE_LAT, 3: datapath latency in cycles from accepted pixel to filtered output; range 1–15.
- BORDER, 2: lines and columns suppressed at top and left edges in filtered modes.

Ports:
- iCLK  in  1  system clock; all logic on rising edge.
- iRST  in  1  reset, synchronous, active-low.
- iFVAL  in  1  sensor frame valid.
- iDVAL  in  1  sensor pixel valid; counted only while a frame is active.
- iMODE_REQ  in  2  requested mode: 00 bypass, 01 vertical, 10 horizontal, 11 reserved.
- iMODE_WE  in  1  one-cycle write strobe for iMODE_REQ.
- oX_Cont  out  11  column of the pixel accepted on the previous edge.
- oY_Cont  out  11  line of the pixel accepted on the previous edge.
- oPIX_VAL  out  1  iDVAL accepted on the previous edge; qualifies oX_Cont/oY_Cont.
- oVERTICAL  out  1  convolution direction: 1 vertical, 0 horizontal.
- oBYPASS  out  1  filter bypass.
- oMODE_ACK  out  1  one-cycle pulse when a pending mode is applied.
- oDVAL  out  1  output valid, aligned to datapath output.
- oFRAME_DONE  out  1  one-cycle pulse at end of drain.
- oSHORT  out  1  one-cycle pulse when iFVAL falls before IMG_W*IMG_H pixels are accepted.

## Operation
- States: IDLE, WAIT_FRAME, ACTIVE, DRAIN.
- Reset (iRST=0 at an edge):
  - All outputs are 0, except oVERTICAL=1 (default mode vertical).
  - Pending request is cleared, all counters are 0, state is IDLE.
- IDLE → WAIT_FRAME on the first cycle after reset.
- WAIT_FRAME → ACTIVE on an iFVAL rising edge (iFVAL=1, registered previous iFVAL=0).
  - In that same cycle, a pending valid mode is applied: oVERTICAL/oBYPASS are updated, oMODE_ACK pulses, and pending is cleared.
  - X and Y are zeroed.
  - If iDVAL=1 in that cycle, it is accepted as pixel (0,0).
- ACTIVE:
  - Each iDVAL=1 cycle accepts one pixel.
  - X increments; at X=IMG_W-1, X wraps to 0 and Y increments.
  - When pixel (IMG_W-1, IMG_H-1) is accepted, the next state is DRAIN.
  - If iFVAL=0 before that pixel: oSHORT pulses and the next state is DRAIN.
  - If iFVAL=0 and iDVAL=1 in the same cycle, the pixel is not accepted.
- DRAIN:
  - Lasts exactly PIPE_LAT cycles.
  - oFRAME_DONE pulses on the last DRAIN cycle; the next state is WAIT_FRAME.
  - iDVAL is ignored.
- Mode requests:
  - iMODE_WE with code 00/01/10 overwrites the pending register in any state except IDLE; the last write before a frame start wins.
  - Code 11 is dropped: pending is unchanged and no ack is issued.
  - A write in the same cycle as an iFVAL rising edge is pending for the next frame, not this one.
- oDVAL:
  - Accepted-pixel valid is delayed PIPE_LAT cycles through a shift register, alongside the X/Y of each pixel.
  - In filtered modes: oDVAL = delayed valid AND delayed X ≥ BORDER AND delayed Y ≥ BORDER.
  - In bypass: oDVAL = delayed valid.
- Arithmetic:
  - X/Y counters are 11 bits and never exceed IMG_W-1 / IMG_H-1.
  - oSHORT is not a sticky error; the frame counter (when enabled) still increments.

## Timing
- oX_Cont, oY_Cont and oPIX_VAL are registered: latency 1 cycle from the accepting edge.
- oDVAL latency from the accepting edge is PIPE_LAT cycles, independent of oPIX_VAL.
- The mode change is visible on the cycle after the iFVAL rising edge, together with oMODE_ACK.
- oFRAME_DONE occurs PIPE_LAT cycles after the last accepted pixel; that cycle's delayed valid belongs to the last pixel.
- Reset mid-frame has effect on the next edge:
  - state becomes IDLE and the delay line is cleared (no residual oDVAL);
  - the mode returns to vertical.
- An iFVAL rising edge during DRAIN is missed; the controller waits for the next rising edge.

## Configuration
- IMGPROC_CTRL_STATS_EN defined:
  - Adds output oFRAME_CNT (16 bits, reset 0).
  - It increments on each oFRAME_DONE and wraps from 0xFFFF to 0.
  - Adds output oSHORT_CNT (8 bits), which saturates at 0xFF.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- **Full frame:** IMG_W=8, IMG_H=4, PIPE_LAT=3, iDVAL continuous.
  - 32 oPIX_VAL pulses; last one has oX_Cont=7, oY_Cont=3.
  - oDVAL count = 6*2 = 12.
  - oFRAME_DONE 3 cycles after the last pixel.
- **Mode change mid-frame:** iMODE_REQ=10 with iMODE_WE during ACTIVE.
  - oVERTICAL stays 1 until the next iFVAL rise.
  - Then oVERTICAL=0 and oMODE_ACK pulses once.
- **Reserved code:** iMODE_REQ=11 write → no ack; mode unchanged across the next frame start.
- **Short frame:** iFVAL drops after 10 pixels.
  - oSHORT pulses once.
  - oFRAME_DONE follows PIPE_LAT cycles later.
  - The next frame restarts at (0,0).
- **Bypass with gapped iDVAL:** alternating iDVAL in bypass → oDVAL follows delayed iDVAL exactly, including border pixels.
- **Reset mid-frame:** iRST=0 at pixel 15.
  - Next cycle: all outputs 0, oVERTICAL=1.
  - No oDVAL emerges from the flushed delay line.

Source files
------------

// File: rtl/imgproc_frame_ctrl_if.sv
// rtl/imgproc_frame_ctrl_if.sv - sensor strobes, mode requests and datapath controls of the frame controller
// Extra statistics signals exist only when IMGPROC_CTRL_STATS_EN is defined.
interface imgproc_frame_ctrl_if;
    logic        iFVAL;
    logic        iDVAL;
    logic [1:0]  iMODE_REQ;
    logic        iMODE_WE;
    logic [10:0] oX_Cont;
    logic [10:0] oY_Cont;
    logic        oPIX_VAL;
    logic        oVERTICAL;
    logic        oBYPASS;
    logic        oMODE_ACK;
    logic        oDVAL;
    logic        oFRAME_DONE;
    logic        oSHORT;
`ifdef IMGPROC_CTRL_STATS_EN
    logic [15:0] oFRAME_CNT;
    logic [7:0]  oSHORT_CNT;

    modport master (
        output iFVAL, iDVAL, iMODE_REQ, iMODE_WE,
        input  oX_Cont, oY_Cont, oPIX_VAL, oVERTICAL, oBYPASS, oMODE_ACK,
        input  oDVAL, oFRAME_DONE, oSHORT, oFRAME_CNT, oSHORT_CNT
    );
    modport slave (
        input  iFVAL, iDVAL, iMODE_REQ, iMODE_WE,
        output oX_Cont, oY_Cont, oPIX_VAL, oVERTICAL, oBYPASS, oMODE_ACK,
        output oDVAL, oFRAME_DONE, oSHORT, oFRAME_CNT, oSHORT_CNT
    );
`else
    modport master (
        output iFVAL, iDVAL, iMODE_REQ, iMODE_WE,
        input  oX_Cont, oY_Cont, oPIX_VAL, oVERTICAL, oBYPASS, oMODE_ACK,
        input  oDVAL, oFRAME_DONE, oSHORT
    );
    modport slave (
        input  iFVAL, iDVAL, iMODE_REQ, iMODE_WE,
        output oX_Cont, oY_Cont, oPIX_VAL, oVERTICAL, oBYPASS, oMODE_ACK,
        output oDVAL, oFRAME_DONE, oSHORT
    );
`endif
endinterface

// File: rtl/imgproc_frame_ctrl.sv
// rtl/imgproc_frame_ctrl.sv - frame/pixel sequencer, frame-boundary mode switch and latency-aligned output valid
// Frame and short-frame counters are built only when IMGPROC_CTRL_STATS_EN is defined.
module imgproc_frame_ctrl #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int PIPE_LAT = 3,
    parameter int BORDER   = 2
) (
    input logic                 iCLK,
    input logic                 iRST,
    imgproc_frame_ctrl_if.slave ctrl
);

    localparam logic [10:0] X_LAST     = 11'(IMG_W - 1);
    localparam logic [10:0] Y_LAST     = 11'(IMG_H - 1);
    localparam logic [10:0] BORDER_V   = 11'(BORDER);
    localparam logic [3:0]  DRAIN_LAST = 4'(PIPE_LAT - 1);
    localparam int          DLY_W      = PIPE_LAT * 11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        ACTIVE,
        DRAIN
    } stateE;

    stateE state;
    stateE stateNext;

    logic        fvalPrev;
    logic        pendValid;
    logic [1:0]  pendCode;
    logic        vertical;
    logic        bypass;
    logic        modeAck;
    logic [10:0] xCnt;
    logic [10:0] yCnt;
    logic [3:0]  drainCnt;

    // Stage 0 of the delay line doubles as the registered coordinate output.
    logic [PIPE_LAT-1:0]       dlyVal;
    logic [PIPE_LAT-1:0][10:0] dlyX;
    logic [PIPE_LAT-1:0][10:0] dlyY;

    logic        fvalRise;
    logic        accept;
    logic        startFrame;
    logic        shortEvt;
    logic        drainDone;
    logic        lastPix;
    logic [10:0] posX;
    logic [10:0] posY;
    logic        modeWrite;

    assign fvalRise  = ctrl.iFVAL && !fvalPrev;
    assign modeWrite = (state != IDLE) && ctrl.iMODE_WE && (ctrl.iMODE_REQ != 2'b11);

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        accept     = 1'b0;
        startFrame = 1'b0;
        shortEvt   = 1'b0;
        drainDone  = 1'b0;
        posX       = xCnt;
        posY       = yCnt;
        case (state)
            IDLE: stateNext = WAIT_FRAME;
            WAIT_FRAME: begin
                if (fvalRise) begin
                    stateNext  = ACTIVE;
                    startFrame = 1'b1;
                    posX       = '0;
                    posY       = '0;
                    accept     = ctrl.iDVAL;
                end
            end
            ACTIVE: begin
                // A pixel presented together with the falling frame valid is dropped.
                if (!ctrl.iFVAL) begin
                    shortEvt  = 1'b1;
                    stateNext = DRAIN;
                end else begin
                    accept = ctrl.iDVAL;
                end
            end
            DRAIN: begin
                if (drainCnt == DRAIN_LAST) begin
                    drainDone = 1'b1;
                    stateNext = WAIT_FRAME;
                end
            end
            default: stateNext = IDLE;
        endcase
        lastPix = accept && (posX == X_LAST) && (posY == Y_LAST);
        if (lastPix) begin
            stateNext = DRAIN;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            fvalPrev  <= 1'b0;
            pendValid <= 1'b0;
            pendCode  <= 2'b00;
            vertical  <= 1'b1;
            bypass    <= 1'b0;
            modeAck   <= 1'b0;
            xCnt      <= '0;
            yCnt      <= '0;
            drainCnt  <= '0;
            dlyVal    <= '0;
            dlyX      <= '0;
            dlyY      <= '0;
        end else begin
            fvalPrev <= ctrl.iFVAL;
            modeAck  <= 1'b0;
            if (startFrame && pendValid) begin
                case (pendCode)
                    2'b00: bypass <= 1'b1;
                    2'b01: begin
                        vertical <= 1'b1;
                        bypass   <= 1'b0;
                    end
                    default: begin
                        vertical <= 1'b0;
                        bypass   <= 1'b0;
                    end
                endcase
                modeAck   <= 1'b1;
                pendValid <= 1'b0;
            end
            // Placed after the apply so a write on the frame-start cycle survives for the next frame.
            if (modeWrite) begin
                pendValid <= 1'b1;
                pendCode  <= ctrl.iMODE_REQ;
            end
            if (accept) begin
                if (posX == X_LAST) begin
                    xCnt <= '0;
                    yCnt <= (posY == Y_LAST) ? 11'd0 : posY + 11'd1;
                end else begin
                    xCnt <= posX + 11'd1;
                    yCnt <= posY;
                end
            end else if (startFrame) begin
                xCnt <= '0;
                yCnt <= '0;
            end
            drainCnt <= (state == DRAIN && !drainDone) ? drainCnt + 4'd1 : 4'd0;
            dlyVal   <= PIPE_LAT'({dlyVal, accept});
            dlyX     <= DLY_W'({dlyX, posX});
            dlyY     <= DLY_W'({dlyY, posY});
        end
    end

`ifdef IMGPROC_CTRL_STATS_EN
    logic [15:0] frameCnt;
    logic [7:0]  shortCnt;

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            frameCnt <= '0;
            shortCnt <= '0;
        end else begin
            if (drainDone) begin
                frameCnt <= frameCnt + 16'd1;
            end
            if (shortEvt && shortCnt != 8'hFF) begin
                shortCnt <= shortCnt + 8'd1;
            end
        end
    end

    assign ctrl.oFRAME_CNT = frameCnt;
    assign ctrl.oSHORT_CNT = shortCnt;
`endif

    assign ctrl.oX_Cont     = dlyX[0];
    assign ctrl.oY_Cont     = dlyY[0];
    assign ctrl.oPIX_VAL    = dlyVal[0];
    assign ctrl.oVERTICAL   = vertical;
    assign ctrl.oBYPASS     = bypass;
    assign ctrl.oMODE_ACK   = modeAck;
    assign ctrl.oFRAME_DONE = (state == DRAIN) && (drainCnt == DRAIN_LAST);
    assign ctrl.oSHORT      = shortEvt;
    // Border masking uses the coordinates that travelled with the pixel, not the live counters.
    assign ctrl.oDVAL       = dlyVal[PIPE_LAT-1] &&
                              (bypass || (dlyX[PIPE_LAT-1] >= BORDER_V && dlyY[PIPE_LAT-1] >= BORDER_V));

endmodule
